// File: rtl/lebug_pkg.sv
// Shared types and constants for the chain scheduler slice.
package lebug_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // A chain count of zero would stall issue forever, so requests are raised to this floor.
  localparam logic [7:0] MIN_CHAINS = 8'd1;

  function automatic logic [7:0] clamp_chains(input logic [7:0] req, input logic [7:0] max_chains);
    logic [7:0] res;
    if (req < MIN_CHAINS) begin
      res = MIN_CHAINS;
    end else if (req > max_chains) begin
      res = max_chains;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/vector_fifo.sv
// Synchronous FIFO with full/empty/count; push when full and pop when empty are ignored.
module vector_fifo
  import lebug_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {(PW + 1){1'b0}});
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {(PW + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/chain_scheduler.sv
// Buffers input vectors and re-issues each one once per active firmware chain, tagged by chain id.
module chain_scheduler
  import lebug_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tracing,
  input  logic                            valid_in,
  input  logic                            eof_in,
  input  logic                            bof_in,
  input  logic [N*DATA_WIDTH-1:0]         vector_in,
  output logic                            ready_out,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  output logic [N*DATA_WIDTH-1:0]         vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]   chainId_out,
  output logic                            valid_out,
  output logic                            eof_out,
  output logic                            bof_out,
  output logic                            overflow
);

  localparam int VW = N * DATA_WIDTH;
  localparam int EW = VW + 2;
  localparam int CW = $clog2(MAX_CHAINS);
  localparam int KW = CW + 1;
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]    MAX_C8 = 8'(MAX_CHAINS);
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0] Q_ONE  = {{(QW-1){1'b0}}, 1'b1};

  logic [EW-1:0] w_head;
  logic [QW-1:0] w_count;
  logic          w_full, w_empty, w_push, w_pop;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [KW-1:0] r_active, r_pending, w_eff;
  logic          w_issue, w_load_active, w_more;
  logic [VW-1:0] r_vector;
  logic [CW-1:0] r_chain;
  logic          r_valid, r_eof, r_bof, r_overflow;

  assign ready_out = ~w_full;
  assign w_push    = valid_in & ~w_full;
  assign w_more    = (w_count > Q_ONE) | w_push;

  vector_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({eof_in, bof_in, vector_in}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next state/counter; IDLE issues the first beat itself so acceptance-to-output stays at two cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_issue       = 1'b0;
    w_pop         = 1'b0;
    w_load_active = 1'b0;
    w_eff         = r_active;
    case (r_state)
      IDLE: begin
        w_eff         = r_pending;
        w_load_active = 1'b1;
        w_cnt_nxt     = {CW{1'b0}};
        w_issue       = ~w_empty & tracing;
      end
      ISSUE: begin
        w_issue = ~w_empty & tracing;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_issue) begin
      if ({1'b0, r_cnt} == (w_eff - K_ONE)) begin
        w_pop         = 1'b1;
        w_load_active = 1'b1;
        w_cnt_nxt     = {CW{1'b0}};
        w_state_nxt   = w_more ? ISSUE : IDLE;
      end else begin
        w_cnt_nxt   = r_cnt + C_ONE;
        w_state_nxt = ISSUE;
      end
    end else begin
      w_pop = 1'b0;
    end
  end

  // Control state, chain counts and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= {CW{1'b0}};
      r_active   <= K_ONE;
      r_pending  <= K_ONE;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        r_pending <= KW'(clamp_chains(configData, MAX_C8));
      end
      if (w_load_active) begin
        r_active <= r_pending;
      end
      if (valid_in && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output register; payload holds while no beat is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_eof    <= 1'b0;
      r_bof    <= 1'b0;
      r_chain  <= {CW{1'b0}};
      r_vector <= {VW{1'b0}};
    end else if (w_issue) begin
      r_valid  <= 1'b1;
      r_eof    <= w_head[VW+1];
      r_bof    <= w_head[VW];
      r_chain  <= r_cnt;
      r_vector <= w_head[VW-1:0];
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign valid_out   = r_valid;
  assign eof_out     = r_eof;
  assign bof_out     = r_bof;
  assign chainId_out = r_chain;
  assign vector_out  = r_vector;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_chain_scheduler.sv
// Directed bench for chain_scheduler: each task drives one scenario and checks captured beats inline.
module tb_chain_scheduler;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tracing, valid_in, eof_in, bof_in;
  logic [VW-1:0] vector_in;
  logic          ready_out;
  logic [7:0]    configId, configData;
  logic [VW-1:0] vector_out;
  logic [1:0]    chainId_out;
  logic          valid_out, eof_out, bof_out, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cap_cyc[$];
  int cap_chain[$];
  logic [VW-1:0] cap_data[$];
  logic cap_eof[$];
  logic cap_bof[$];
  logic [VW-1:0] zero_v = '0;

  chain_scheduler #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
    .bof_in(bof_in), .vector_in(vector_in), .ready_out(ready_out), .configId(configId),
    .configData(configData), .vector_out(vector_out), .chainId_out(chainId_out),
    .valid_out(valid_out), .eof_out(eof_out), .bof_out(bof_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mkvec(input logic [31:0] k);
    return {N{32'hC0DE_0000 ^ k}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out === 1'b1) begin
      cap_cyc.push_back(cyc);
      cap_chain.push_back(int'(chainId_out));
      cap_data.push_back(vector_out);
      cap_eof.push_back(eof_out);
      cap_bof.push_back(bof_out);
    end
  endtask

  task automatic clear_cap();
    cap_cyc.delete(); cap_chain.delete(); cap_data.delete(); cap_eof.delete(); cap_bof.delete();
    cyc = 0;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; eof_in = 1'b0; bof_in = 1'b0; vector_in = '0;
    configId = 8'hFF; configData = 8'h00;
  endtask

  task automatic set_chains(input logic [7:0] v);
    configId = 8'h00; configData = v;
    tick();
    configId = 8'hFF;
  endtask

  task automatic do_reset();
    idle_inputs();
    tracing = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    tracing = 1'b1;
    #3 rst_n = 1'b0;
    #2;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (chainId_out !== 2'd0) begin failures++; $display("FAIL reset_chain got=%0d exp=0", chainId_out); end
    checks++; if (vector_out !== zero_v) begin failures++; $display("FAIL reset_vector got=%h exp=0", vector_out); end
    checks++; if ({eof_out, bof_out} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {eof_out, bof_out}); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    tick(); tick();
    rst_n = 1'b1;
    clear_cap();
    repeat (4) tick();
    checks++; if (cap_cyc.size() != 0) begin failures++; $display("FAIL reset_idle_beats got=%0d exp=0", cap_cyc.size()); end
  endtask

  task automatic test_three_chains();
    logic [VW-1:0] va;
    va = mkvec(32'd1);
    do_reset(); set_chains(8'd3); clear_cap();
    valid_in = 1'b1; vector_in = va; bof_in = 1'b1; eof_in = 1'b1;
    tick(); idle_inputs();
    repeat (7) tick();
    checks++; if (cap_cyc.size() != 3) begin failures++; $display("FAIL chain3_count got=%0d exp=3", cap_cyc.size()); end
    for (int i = 0; i < 3 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != 2 + i || cap_chain[i] != i || cap_data[i] !== va || cap_eof[i] !== 1'b1 || cap_bof[i] !== 1'b1) begin
        failures++;
        $display("FAIL chain3_beat%0d got cyc=%0d chain=%0d eof=%b bof=%b data=%h exp cyc=%0d chain=%0d eof=1 bof=1 data=%h",
                 i, cap_cyc[i], cap_chain[i], cap_eof[i], cap_bof[i], cap_data[i], 2 + i, i, va);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(); set_chains(8'd1); tracing = 1'b0; clear_cap();
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1; vector_in = mkvec(32'(16 + k));
      tick();
    end
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL ovf_ready_full got=%b exp=0", ready_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    vector_in = mkvec(32'd99);
    tick(); idle_inputs();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    tracing = 1'b1;
    repeat (10) tick();
    checks++; if (cap_cyc.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", cap_cyc.size()); end
    for (int i = 0; i < 4 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != 6 + i || cap_chain[i] != 0 || cap_data[i] !== mkvec(32'(16 + i))) begin
        failures++;
        $display("FAIL ovf_beat%0d got cyc=%0d chain=%0d data=%h exp cyc=%0d chain=0 data=%h",
                 i, cap_cyc[i], cap_chain[i], cap_data[i], 6 + i, mkvec(32'(16 + i)));
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL ovf_ready_drained got=%b exp=1", ready_out); end
  endtask

  task automatic test_clamp();
    logic [VW-1:0] va, vb;
    va = mkvec(32'd2); vb = mkvec(32'd3);
    do_reset(); set_chains(8'd7); clear_cap();
    valid_in = 1'b1; vector_in = va;
    tick(); idle_inputs();
    repeat (8) tick();
    checks++; if (cap_cyc.size() != 4) begin failures++; $display("FAIL clamp7_count got=%0d exp=4", cap_cyc.size()); end
    for (int i = 0; i < 4 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != 2 + i || cap_chain[i] != i || cap_data[i] !== va) begin
        failures++;
        $display("FAIL clamp7_beat%0d got cyc=%0d chain=%0d exp cyc=%0d chain=%0d", i, cap_cyc[i], cap_chain[i], 2 + i, i);
      end
    end
    set_chains(8'd0); clear_cap();
    valid_in = 1'b1; vector_in = vb;
    tick(); idle_inputs();
    repeat (6) tick();
    checks++; if (cap_cyc.size() != 1) begin failures++; $display("FAIL clamp0_count got=%0d exp=1", cap_cyc.size()); end
    if (cap_cyc.size() > 0) begin
      checks++;
      if (cap_cyc[0] != 2 || cap_chain[0] != 0 || cap_data[0] !== vb) begin
        failures++;
        $display("FAIL clamp0_beat got cyc=%0d chain=%0d exp cyc=2 chain=0", cap_cyc[0], cap_chain[0]);
      end
    end
  endtask

  task automatic test_config_midvector();
    logic [VW-1:0] va, vb;
    int exp_cyc[6] = '{2, 3, 4, 5, 6, 7};
    int exp_ch[6]  = '{0, 1, 2, 3, 0, 1};
    va = mkvec(32'd4); vb = mkvec(32'd5);
    do_reset(); set_chains(8'd4); clear_cap();
    valid_in = 1'b1; vector_in = va; tick();
    vector_in = vb; tick();
    idle_inputs(); configId = 8'h00; configData = 8'd2; tick();
    configId = 8'hFF;
    repeat (8) tick();
    checks++; if (cap_cyc.size() != 6) begin failures++; $display("FAIL cfgmid_count got=%0d exp=6", cap_cyc.size()); end
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != exp_cyc[i] || cap_chain[i] != exp_ch[i] || cap_data[i] !== ((i < 4) ? va : vb)) begin
        failures++;
        $display("FAIL cfgmid_beat%0d got cyc=%0d chain=%0d exp cyc=%0d chain=%0d", i, cap_cyc[i], cap_chain[i], exp_cyc[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_tracing_stall();
    logic [VW-1:0] va;
    int exp_cyc[4] = '{2, 6, 7, 8};
    va = mkvec(32'd6);
    do_reset(); set_chains(8'd4); clear_cap();
    valid_in = 1'b1; vector_in = va; tick();
    idle_inputs(); tick();
    tracing = 1'b0; repeat (3) tick();
    tracing = 1'b1; repeat (6) tick();
    checks++; if (cap_cyc.size() != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", cap_cyc.size()); end
    for (int i = 0; i < 4 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != exp_cyc[i] || cap_chain[i] != i || cap_data[i] !== va) begin
        failures++;
        $display("FAIL stall_beat%0d got cyc=%0d chain=%0d exp cyc=%0d chain=%0d", i, cap_cyc[i], cap_chain[i], exp_cyc[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v[3];
    for (int k = 0; k < 3; k++) v[k] = mkvec(32'(40 + k));
    do_reset(); set_chains(8'd2); clear_cap();
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1; vector_in = v[k]; tick();
    end
    idle_inputs();
    repeat (8) tick();
    checks++; if (cap_cyc.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", cap_cyc.size()); end
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      checks++;
      if (cap_cyc[i] != 2 + i || cap_chain[i] != (i % 2) || cap_data[i] !== v[i / 2]) begin
        failures++;
        $display("FAIL b2b_beat%0d got cyc=%0d chain=%0d exp cyc=%0d chain=%0d", i, cap_cyc[i], cap_chain[i], 2 + i, i % 2);
      end
    end
  endtask

  task automatic test_reset_midvector();
    do_reset(); set_chains(8'd4); clear_cap();
    valid_in = 1'b1; vector_in = mkvec(32'd7); tick();
    vector_in = mkvec(32'd8); tick();
    idle_inputs(); tick();
    checks++; if (valid_out !== 1'b1 || chainId_out !== 2'd1) begin failures++; $display("FAIL rstmid_pre got valid=%b chain=%0d exp valid=1 chain=1", valid_out, chainId_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || chainId_out !== 2'd0 || vector_out !== zero_v || eof_out !== 1'b0 || bof_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got valid=%b chain=%0d eof=%b bof=%b exp all 0", valid_out, chainId_out, eof_out, bof_out);
    end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready_out); end
    tick(); tick();
    rst_n = 1'b1;
    clear_cap();
    repeat (10) tick();
    checks++; if (cap_cyc.size() != 0) begin failures++; $display("FAIL rstmid_after got=%0d beats exp=0", cap_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_three_chains();
    test_overflow();
    test_clamp();
    test_config_midvector();
    test_tracing_stall();
    test_back_to_back();
    test_reset_midvector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chain_scheduler.md
CHAIN_SCHEDULER -- requirements
Module: chain_scheduler

Interface
REQ-001 Parameter N, default 8: vector lanes.
REQ-002 Parameter DATA_WIDTH, default 32: lane width in bits.
REQ-003 Parameter MAX_CHAINS, default 4: maximum firmware chains per input vector; power of two, at least 2.
REQ-004 Parameter PERSONAL_CONFIG_ID, default 0: configId value addressed to this block.
REQ-005 Parameter FIFO_DEPTH, default 4: input vector buffer entries; power of two.
REQ-006 Port clk, input, 1: single clock, rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port tracing, input, 1: issue enable.
REQ-009 Port valid_in, input, 1: input vector valid.
REQ-010 Port eof_in, input, 1: last vector of frame.
REQ-011 Port bof_in, input, 1: first vector of frame.
REQ-012 Port vector_in, input, N x DATA_WIDTH: input vector.
REQ-013 Port ready_out, input-side output, 1: buffer can accept this cycle.
REQ-014 Port configId, input, 8: configuration target ID.
REQ-015 Port configData, input, 8: active chain count.
REQ-016 Port vector_out, output, N x DATA_WIDTH: issued vector.
REQ-017 Port chainId_out, output, clog2(MAX_CHAINS): chain tag of the issued vector.
REQ-018 Port valid_out, eof_out and bof_out, output, 1 each: issued qualifiers.
REQ-019 Port overflow, output, 1: sticky flag for a dropped input.

Function
REQ-020 ready_out SHALL equal not-full of the buffer, driven combinationally from registered state.
REQ-021 The block SHALL accept an input when valid_in and ready_out are both high; vector, eof and bof are stored together.
REQ-022 When valid_in is high and the buffer is full, the input SHALL be dropped and overflow SHALL set and hold until reset, even if a pop occurs in the same cycle.
REQ-023 On configId==PERSONAL_CONFIG_ID, configData SHALL be captured into pending_chains as follows: 0 maps to 1; values above MAX_CHAINS map to MAX_CHAINS.
REQ-024 active_chains SHALL load from pending_chains only in IDLE or at completion of a vector; the change never applies mid-vector.
REQ-025 States SHALL be IDLE and ISSUE.
REQ-026 IDLE transitions to ISSUE when the buffer is not empty and tracing=1, with chain counter cleared to 0.
REQ-027 In ISSUE with tracing=1, the block SHALL issue one beat per cycle: the buffer head, chainId_out = counter, and counter increment.
REQ-028 When counter == active_chains-1 the beat SHALL pop the head; the next state is ISSUE at counter 0 if further entries remain, else IDLE.
REQ-029 In ISSUE with tracing=0, the block SHALL hold counter and head and drive valid_out=0; accepting into the buffer continues.
REQ-030 All outputs SHALL be registered: valid_out is high one cycle after the issuing state/counter cycle, and the latency from input acceptance (empty buffer, tracing=1) to first valid_out is 2 cycles.
REQ-031 eof_out and bof_out SHALL replicate the head's flags on every chain beat of that vector.
REQ-032 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-033 Throughput SHALL be one vector per active_chains cycles; back-to-back vectors have no bubble.

Reset
REQ-034 On rst_n low, the block SHALL asynchronously clear the buffer pointers and count, state to IDLE, counter, valid_out, eof_out, bof_out, chainId_out, vector_out and overflow, and set active_chains and pending_chains to 1.
REQ-035 Reset mid-vector SHALL discard all buffered and in-flight vectors; no beat is issued after release until a new acceptance.

Structure
REQ-036 The state enum and the chain-count clamp constant SHALL reside in shared package lebug_pkg.
REQ-037 The buffer SHALL be sub-module vector_fifo, a synchronous FIFO with full/empty flags and asynchronous active-low reset.

Verification
REQ-038 Scenario: active_chains=3, one vector accepted at cycle 0 -> valid_out in cycles 2,3,4 with chainId 0,1,2 and identical data.
REQ-039 Scenario: fill 4 entries with tracing=0, then 5th valid_in -> ready_out=0, overflow=1, and only 4 vectors are issued later.
REQ-040 Scenario: configData=7 with MAX_CHAINS=4 -> chainIds 0..3; configData=0 -> single beat with chainId 0.
REQ-041 Scenario: config changed to 2 during chain 1 of 4 -> current vector completes 4 beats, and the next vector issues 2 beats.
REQ-042 Scenario: tracing dropped at chain 1 for 3 cycles -> valid_out=0 for 3 cycles, then resume at chain 1 with no repeats.
REQ-043 Scenario: rst_n asserted mid-vector with 2 entries buffered -> all outputs 0 immediately, and no valid_out after release without new input.
